// File: rtl/ts_fifo_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ts_fifo_reader
// Purpose  : Paced consumer for four per-stream TS FIFOs. Hunts the sync byte
//            and emits framed PKT_LEN-byte packets on ts_*.
//            Optional macro TS_STATS_EN adds pkt_cnt / drop_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ts_fifo_reader #(
    parameter int         DIV     = 4,
    parameter int         PKT_LEN = 188,
    parameter logic [7:0] SYNC    = 8'h47
) (
    input  logic        clk2,
    input  logic        rst,
    input  logic [3:0]  valid,
    input  logic [1:0]  mux_ctrl,
    input  logic [3:0]  fifo_empty,
    input  logic [31:0] fifo_rdata,
    output logic [3:0]  fifo_rd,
    output logic [7:0]  ts_data,
    output logic        ts_valid,
    output logic        ts_sop,
    output logic        ts_eop,
    output logic        sync_err,
    output logic        pkt_abort
`ifdef TS_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [7:0]       LEN_LAST = 8'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] pace_q;
    logic [CNT_W-1:0] pace_d;
    logic [1:0]       ch_q;
    logic [7:0]       byte_cnt_q;
    logic             rd_pend_q;

    logic             w_tick;
    logic             w_sel_ok;
    logic             w_last_inflight;
    logic [7:0]       w_cap_byte;

    always_comb begin
        w_tick = (|valid) && (pace_q == CNT_LAST);
        if (!(|valid) || w_tick) begin
            pace_d = '0;
        end else begin
            pace_d = pace_q + 1'b1;
        end
        w_sel_ok   = valid[mux_ctrl] && !fifo_empty[mux_ctrl];
        w_cap_byte = fifo_rdata[{ch_q, 3'b000} +: 8];
        // With DIV=2 the next tick coincides with the capture of the final
        // byte; suppress that read so no byte of the next packet is consumed.
        w_last_inflight = rd_pend_q && (state_q == STREAM) && (byte_cnt_q == LEN_LAST);
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q    <= IDLE;
            pace_q     <= '0;
            ch_q       <= 2'd0;
            byte_cnt_q <= 8'd0;
            rd_pend_q  <= 1'b0;
            fifo_rd    <= 4'd0;
            ts_data    <= 8'd0;
            ts_valid   <= 1'b0;
            ts_sop     <= 1'b0;
            ts_eop     <= 1'b0;
            sync_err   <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            pace_q    <= pace_d;
            rd_pend_q <= |fifo_rd;
            fifo_rd   <= 4'd0;
            ts_valid  <= 1'b0;
            ts_sop    <= 1'b0;
            ts_eop    <= 1'b0;
            sync_err  <= 1'b0;
            pkt_abort <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (w_tick && w_sel_ok) begin
                        ch_q              <= mux_ctrl;
                        fifo_rd[mux_ctrl] <= 1'b1;
                        state_q           <= HUNT;
                    end
                end

                HUNT, STREAM: begin
                    if (!valid[ch_q]) begin
                        // Stream withdrawn: drop any byte in flight, no eop.
                        state_q    <= IDLE;
                        byte_cnt_q <= 8'd0;
                        rd_pend_q  <= 1'b0;
                        pkt_abort  <= (state_q == STREAM);
                    end else begin
                        if (w_tick && !fifo_empty[ch_q] && !w_last_inflight) begin
                            fifo_rd[ch_q] <= 1'b1;
                        end
                        if (rd_pend_q) begin
                            if (state_q == HUNT) begin
                                if (w_cap_byte == SYNC) begin
                                    ts_data    <= w_cap_byte;
                                    ts_valid   <= 1'b1;
                                    ts_sop     <= 1'b1;
                                    byte_cnt_q <= 8'd1;
                                    state_q    <= STREAM;
                                end else begin
                                    sync_err <= 1'b1;
                                end
                            end else begin
                                ts_data  <= w_cap_byte;
                                ts_valid <= 1'b1;
                                if (byte_cnt_q == LEN_LAST) begin
                                    ts_eop     <= 1'b1;
                                    byte_cnt_q <= 8'd0;
                                    state_q    <= IDLE;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 8'd1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    byte_cnt_q <= 8'd0;
                end
            endcase
        end
    end

`ifdef TS_STATS_EN
    always_ff @(posedge clk2) begin
        if (rst) begin
            pkt_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (ts_valid && ts_eop) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (sync_err) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
